// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch -- instruction fetch stage
//
// Holds the program counter and issues in-order word reads to instruction
// memory. Returned words are tagged with their PC and held in a small FIFO.
// The FIFO presents them to the IR loader over a valid/ready handshake.
// A redirect pulse flushes buffered and in-flight fetches and restarts
// fetch at a new PC.
//
// Optional feature macro: IFETCH_STALL_CNT_EN
//   When defined, the stall_cnt output is added. It is a saturating count of
//   cycles in which ir_ready=1 and ir_valid=0.
//
// Parameters
//   FIFO_DEPTH  fetch buffer entries (power of 2, >= 2). It also caps the
//               total of in-flight plus buffered words.
//   ADDR_W      word-address width of the PC and of instruction memory
//   RESET_PC    PC loaded on reset
//
// Ports
//   clk             system clock; all state changes on the rising edge
//   rst_n           asynchronous active-low reset
//   imem_req        read request this cycle (memory always accepts it)
//   imem_addr       word address of the request (the current PC)
//   imem_rvalid     read data valid; responses come back in request order
//   imem_rdata      instruction word
//   halt            stop issuing new requests while high
//   redirect_valid  one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc     new PC
//   ir_valid        ir_data/ir_pc hold a fetched instruction
//   ir_ready        IR loader accepts this cycle
//   ir_data         instruction word to the IR
//   ir_pc           PC of ir_data
//   stall_cnt       (IFETCH_STALL_CNT_EN only) empty-while-ready cycle count
// ---------------------------------------------------------------------------
module inst_fetch #(
  parameter int                FIFO_DEPTH = 4,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [31:0]       ir_data,
  output logic [ADDR_W-1:0] ir_pc
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]    CREDITS  = (CNT_W + 1)'(FIFO_DEPTH);

  // Architectural state
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
  logic [CNT_W-1:0]  outstanding_reg, outstanding_next;
  logic [CNT_W-1:0]  discard_reg, discard_next;
  // Goes high one clock after reset release. This keeps imem_req low
  // during reset and the release cycle.
  logic              run_reg;

  // Fetch buffer
  logic [31:0]       data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [FIFO_DEPTH-1:0] slot_we;

  logic [CNT_W:0] in_use;
  logic           issue;
  logic           push;
  logic           pop;

  // The credit check counts buffered words plus words still in flight.
  // A response therefore always finds room.
  // The check uses registered state only, so ir_ready never reaches imem_req.
  assign in_use   = {1'b0, count_reg} + {1'b0, outstanding_reg};
  assign issue    = run_reg && !halt && !redirect_valid && (in_use < CREDITS);
  assign imem_req = issue;
  assign imem_addr = pc_reg;

  // A response arriving with a redirect is dropped. Any earlier stale
  // responses are then dropped through discard_reg.
  assign push = imem_rvalid && !redirect_valid && (discard_reg == '0);
  assign pop  = ir_valid && ir_ready;

  assign ir_valid = (count_reg != '0);
  assign ir_data  = data_mem[rd_ptr_reg];
  assign ir_pc    = pc_mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot_we
      assign slot_we[gi] = push && (wr_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  always_comb begin
    pc_next          = pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    count_next       = count_reg;

    // Issue is blocked during a redirect. So at most one of +1/-1 applies
    // on a redirect cycle, and the redirect cycle needs no special case.
    if (issue && !imem_rvalid) begin
      outstanding_next = outstanding_reg + CNT_ONE;
    end else if (!issue && imem_rvalid) begin
      outstanding_next = outstanding_reg - CNT_ONE;
    end

    if (redirect_valid) begin
      pc_next      = redirect_pc;
      resp_pc_next = redirect_pc;
      // Every request still in flight after this cycle belongs to the old stream.
      discard_next = imem_rvalid ? (outstanding_reg - CNT_ONE) : outstanding_reg;
      wr_ptr_next  = '0;
      rd_ptr_next  = '0;
      count_next   = '0;
    end else begin
      if (issue) begin
        pc_next = pc_reg + ADDR_ONE;
      end
      if (imem_rvalid && (discard_reg != '0)) begin
        discard_next = discard_reg - CNT_ONE;
      end
      if (push) begin
        resp_pc_next = resp_pc_reg + ADDR_ONE;
        wr_ptr_next  = wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end
      if (push && !pop) begin
        count_next = count_reg + CNT_ONE;
      end else if (!push && pop) begin
        count_next = count_reg - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg         <= 1'b0;
      pc_reg          <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
    end else begin
      run_reg         <= 1'b1;
      pc_reg          <= pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      count_reg       <= count_next;
    end
  end

  // Storage is reset so that ir_data/ir_pc read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (slot_we[i]) begin
          data_mem[i] <= imem_rdata;
          pc_mem[i]   <= resp_pc_reg;
        end
      end
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (ir_ready && !ir_valid && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
`endif

`ifndef SYNTHESIS
  // The credit rule should make these impossible. A hit here means a
  // memory or integration error.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count_reg == FULL_CNT)));
  a_no_outstanding_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (outstanding_reg == '0)));
  a_discard_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    discard_reg <= outstanding_reg);
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch -- self-checking bench for inst_fetch
//
// The memory model returns addr+100 after a programmable latency.
// A table drives a long single-stream run. That run covers start-up,
// backpressure, drain and halt. Hand-written sequences cover redirects
// with stale responses in flight, a redirect with a same-cycle pop,
// PC wrap-around and a redirect under halt.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_rvalid;
  logic [31:0]   imem_rdata;
  logic          halt;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          ir_valid;
  logic          ir_ready;
  logic [31:0]   ir_data;
  logic [AW-1:0] ir_pc;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  inst_fetch #(.FIFO_DEPTH(4), .ADDR_W(AW), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_data        (ir_data),
    .ir_pc          (ir_pc)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat    = 1;
  int cyc    = 0;
  int acc5   = 0;

  logic [AW-1:0] q_addr[$];
  int            q_due[$];

  // Memory model, response side. It advances on each rising edge and
  // drives a response 1 time unit later.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0;
        q_addr.delete();
        q_due.delete();
        imem_rvalid = 1'b0;
      end else begin
        #1;
        cyc++;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'(q_addr[0]) + 32'd100;
          void'(q_addr.pop_front());
          void'(q_due.pop_front());
        end else begin
          imem_rvalid = 1'b0;
        end
      end
    end
  end

  // Memory model, request side. Also counts accepted handshakes of pc 5.
  initial forever begin
    @(negedge clk);
    if (rst_n && imem_req) begin
      q_addr.push_back(imem_addr);
      q_due.push_back(cyc + lat);
    end
    if (rst_n && ir_valid && ir_ready && ir_pc == AW'(5)) acc5++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int l);
    rst_n = 1'b0;
    ir_ready = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    lat = l;
    repeat (2) @(negedge clk);
    chk("rst imem_req", 32'(imem_req), 0);
    chk("rst ir_valid", 32'(ir_valid), 0);
    chk("rst ir_data",  ir_data, 0);
    chk("rst ir_pc",    32'(ir_pc), 0);
    chk("rst imem_addr", 32'(imem_addr), 0);
    rst_n = 1'b1;
  endtask

  // Advance one cycle, apply inputs, and return at the falling edge for sampling.
  task automatic drive(input logic rdy, input logic hlt, input logic rv, input logic [AW-1:0] rpc);
    @(posedge clk); #1;
    ir_ready = rdy; halt = hlt; redirect_valid = rv; redirect_pc = rpc;
    @(negedge clk);
  endtask

  task automatic chk_ir(input string name, input logic [AW-1:0] pc);
    chk({name, " valid"}, 32'(ir_valid), 1);
    chk({name, " pc"},    32'(ir_pc), 32'(pc));
    chk({name, " data"},  ir_data, 32'(pc) + 32'd100);
  endtask

  typedef struct {
    logic          ready;
    logic          halt;
    logic          exp_valid;
    logic [AW-1:0] exp_pc;
    logic          exp_req;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic h, input logic v,
                              input int pc, input logic q, input int a);
    vec_t e;
    e.ready = r; e.halt = h; e.exp_valid = v;
    e.exp_pc = AW'(pc); e.exp_req = q; e.exp_addr = AW'(a);
    vecs.push_back(e);
  endfunction

  initial begin
    // One row per cycle, starting at cycle 1 after reset release, with 1-cycle memory.
    //   ready halt | ir_valid ir_pc | imem_req imem_addr
    add(1, 0, 0, 0, 1, 0);     // 1  first request
    add(1, 0, 0, 0, 1, 1);     // 2
    add(1, 0, 1, 0, 1, 2);     // 3  first instruction
    add(1, 0, 1, 1, 1, 3);     // 4
    add(1, 0, 1, 2, 1, 4);     // 5
    add(0, 0, 1, 3, 1, 5);     // 6  backpressure begins
    add(0, 0, 1, 3, 1, 6);     // 7
    add(0, 0, 1, 3, 0, 7);     // 8  credits exhausted
    for (int i = 9; i <= 15; i++) add(0, 0, 1, 3, 0, 7);
    add(1, 0, 1, 3, 0, 7);     // 16 ready again
    add(1, 0, 1, 4, 1, 7);     // 17
    add(1, 0, 1, 5, 1, 8);     // 18
    add(1, 0, 1, 6, 1, 9);     // 19
    add(1, 0, 1, 7, 1, 10);    // 20
    add(1, 0, 1, 8, 1, 11);    // 21
    add(1, 1, 1, 9, 0, 12);    // 22 halt: no requests, buffer drains
    add(1, 1, 1, 10, 0, 12);   // 23
    add(1, 1, 1, 11, 0, 12);   // 24
    add(1, 1, 0, 0, 0, 12);    // 25
    add(1, 1, 0, 0, 0, 12);    // 26
    add(1, 0, 0, 0, 1, 12);    // 27 resume at next sequential PC
    add(1, 0, 0, 0, 1, 13);    // 28
    add(1, 0, 1, 12, 1, 14);   // 29

    // ---- table-driven stream ----
    do_reset(1);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ready, vecs[i].halt, 1'b0, '0);
      chk($sformatf("cyc%0d imem_req", i + 1), 32'(imem_req), 32'(vecs[i].exp_req));
      chk($sformatf("cyc%0d imem_addr", i + 1), 32'(imem_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("cyc%0d ir_valid", i + 1), 32'(ir_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("cyc%0d ir_pc", i + 1), 32'(ir_pc), 32'(vecs[i].exp_pc));
        chk($sformatf("cyc%0d ir_data", i + 1), ir_data, 32'(vecs[i].exp_pc) + 32'd100);
      end
      $display("vec %0d: ready=%0b halt=%0b req=%0b addr=%0h valid=%0b pc=%0h data=%0h",
               i + 1, vecs[i].ready, vecs[i].halt, imem_req, imem_addr, ir_valid, ir_pc, ir_data);
    end
`ifdef IFETCH_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, 6);
`endif

    // ---- redirect with two stale requests in flight, 3-cycle memory ----
    do_reset(3);
    drive(1, 0, 0, '0);  chk("rd3 c1 addr", 32'(imem_addr), 0);
    drive(1, 0, 0, '0);  chk("rd3 c2 addr", 32'(imem_addr), 1);
    drive(1, 0, 1, AW'(16'h40));
    chk("rd3 redirect suppresses req", 32'(imem_req), 0);
    drive(1, 0, 0, '0);
    chk("rd3 c4 req", 32'(imem_req), 1);
    chk("rd3 c4 addr", 32'(imem_addr), 32'h40);
    for (int c = 4; c <= 7; c++) begin
      if (c > 4) drive(1, 0, 0, '0);
      chk($sformatf("rd3 c%0d stale dropped", c), 32'(ir_valid), 0);
    end
    drive(1, 0, 0, '0);  chk_ir("rd3 c8", AW'(16'h40));
    drive(1, 0, 0, '0);  chk_ir("rd3 c9", AW'(16'h41));
    $display("redirect-latency3: done, errors so far %0d", errors);

    // ---- redirect in the same cycle as a pop of pc 5 ----
    do_reset(1);
    acc5 = 0;
    for (int c = 1; c <= 7; c++) drive(1, 0, 0, '0);
    drive(1, 0, 1, AW'(16'h80));
    chk_ir("rdpop c8", AW'(5));
    chk("rdpop c8 req", 32'(imem_req), 0);
    drive(1, 0, 0, '0);
    chk("rdpop c9 valid", 32'(ir_valid), 0);
    chk("rdpop c9 addr", 32'(imem_addr), 32'h80);
    chk("rdpop c9 req", 32'(imem_req), 1);
    drive(1, 0, 0, '0);  chk("rdpop c10 valid", 32'(ir_valid), 0);
    drive(1, 0, 0, '0);  chk_ir("rdpop c11", AW'(16'h80));
    chk("rdpop pc5 delivered once", 32'(acc5), 1);
    $display("redirect-pop: done, errors so far %0d", errors);

    // ---- PC wrap-around, then redirect under halt ----
    do_reset(1);
    drive(1, 0, 1, AW'(16'hFFFE));  chk("wrap c1 req", 32'(imem_req), 0);
    drive(1, 0, 0, '0);  chk("wrap c2 addr", 32'(imem_addr), 32'hFFFE);
    drive(1, 0, 0, '0);  chk("wrap c3 addr", 32'(imem_addr), 32'hFFFF);
    drive(1, 0, 0, '0);  chk("wrap c4 addr", 32'(imem_addr), 0);
    chk_ir("wrap c4", AW'(16'hFFFE));
    drive(1, 0, 0, '0);  chk_ir("wrap c5", AW'(16'hFFFF));
    drive(1, 0, 0, '0);  chk_ir("wrap c6", AW'(0));
    drive(1, 1, 1, AW'(16'h20));  chk("hrd c7 req", 32'(imem_req), 0);
    drive(1, 1, 0, '0);
    chk("hrd c8 req", 32'(imem_req), 0);
    chk("hrd c8 valid", 32'(ir_valid), 0);
    drive(1, 0, 0, '0);
    chk("hrd c9 req", 32'(imem_req), 1);
    chk("hrd c9 addr", 32'(imem_addr), 32'h20);
    $display("wrap-halt-redirect: done, errors so far %0d", errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage of the 32-bit processor, directly upstream of the IR/GPR execute block. It owns the program counter and issues in-order word reads to instruction memory. Returned words, each tagged with its PC, are buffered in a small FIFO and presented to the IR loader over a valid/ready handshake. A redirect input (jump/branch) flushes buffered and in-flight fetches and restarts at a new PC.

## Interface
- FIFO_DEPTH, 4, fetch buffer entries; power of 2, ≥2; also caps total in-flight plus buffered words
- ADDR_W, 16, word-address width of PC and instruction memory
- RESET_PC, 0, PC loaded on reset
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  read request this cycle; memory always accepts
- imem_addr  out  ADDR_W  word address of request (= PC)
- imem_rvalid  in  1  read data valid; responses in request order, latency ≥1 cycle
- imem_rdata  in  32  instruction word
- halt  in  1  stop issuing new requests while high
- redirect_valid  in  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  in  ADDR_W  new PC
- ir_valid  out  1  ir_data/ir_pc hold a fetched instruction
- ir_ready  in  1  IR loader accepts this cycle
- ir_data  out  32  instruction word to IR
- ir_pc  out  ADDR_W  PC of ir_data

## Operation
- Reset: pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0. Outputs: imem_req=0, ir_valid=0, ir_data=0, ir_pc=0, imem_addr=RESET_PC.
- Issue: imem_req = !halt && !redirect_valid && (occupancy + outstanding) < FIFO_DEPTH. On issue, pc += 1 (wraps modulo 2^ADDR_W), outstanding += 1.
- Response: on imem_rvalid with discard>0, drop word, discard -= 1. Otherwise push {imem_rdata, resp_pc}, then resp_pc += 1. In both cases outstanding -= 1.
- The credit rule makes overflow impossible. A response arriving with the FIFO full is a design error; flag it with an assertion.
- Pop: ir_valid = FIFO non-empty. On ir_valid && ir_ready, pop. ir_data/ir_pc hold stable while ir_valid && !ir_ready.
- Redirect (cycle t):
  - no issue at t; pc and resp_pc load redirect_pc; FIFO is cleared.
  - Any imem_rvalid at t is dropped.
  - discard = outstanding − (imem_rvalid ? 1 : 0).
- Redirect with a same-cycle pop: the handshake completes (instruction delivered), then the flush applies.
- Redirect while halt=1: pc and flush update; issue resumes when halt falls.
- Halt: in-flight responses still land; ir_valid/pop are unaffected.
- Counters: outstanding and discard are clog2(FIFO_DEPTH)+1 bits wide; neither may underflow (assert).
- Reset mid-operation: all state clears immediately. Responses arriving after reset deassertion for pre-reset requests are out of contract; memory is reset together with this block.

## Timing
- Issue→push: memory latency L. Push→ir_valid: +1 cycle (registered FIFO).
- With 1-cycle memory:
  - first request at cycle 1 after reset release; ir_valid at cycle 3.
  - sustained throughput 1 instr/cycle when FIFO_DEPTH ≥ L+2 and ir_ready=1.
- Redirect at t: imem_req with imem_addr=redirect_pc at t+1; first new instruction on ir at t+1+L+1.
- ir_ready has no combinational path to imem_req. Redirect has a combinational path to imem_req (suppress).

## Configuration
- IFETCH_STALL_CNT_EN defined: adds output stall_cnt (32 bits, reset 0), which increments each cycle with ir_ready=1 and ir_valid=0 and saturates at 2^32−1.
- Not defined: no port and no counter; behaviour is otherwise identical.

## Test plan
- Reset release, memory[k]=k+100, 1-cycle latency, ir_ready=1 → ir yields (pc,data) (0,100),(1,101),(2,102)… one per cycle from cycle 3.
- ir_ready=0 for 10 cycles → exactly FIFO_DEPTH=4 words buffered, imem_req=0 while credits are exhausted, and ir_data stays stable. On ready, 0..3 drain in order with no loss.
- Redirect to 0x40 with 2 requests in flight (3-cycle latency) → both stale responses dropped; next ir is (0x40, mem[0x40]).
- Redirect in the same cycle as an accepted pop of pc 5 → pc 5 delivered once; next ir is the redirect target.
- halt=1 for 5 cycles → no imem_req, buffered words still drain. On halt=0, fetch resumes at the next sequential PC.
- PC=0xFFFF with ADDR_W=16 → the following fetch uses address 0x0000 with ir_pc=0x0000. With IFETCH_STALL_CNT_EN, stall_cnt equals the count of empty-ready cycles.
